fifo_rd_stream: RTL and testbench



---
 rtl/conv_stream_pkg.sv | 26 ++
 rtl/stream_skid_fifo.sv | 65 ++++++
 rtl/fifo_rd_stream.sv | 122 ++++++++++++
 tb/tb_fifo_rd_stream.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_stream_pkg.sv
// Shared defaults, width helpers and the beat record for the Conv-path pixel stream.
package conv_stream_pkg;

    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned IMG_W_DEF     = 640;
    localparam int unsigned IMG_H_DEF     = 480;
    localparam int unsigned BUF_DEPTH_DEF = 4;

    // Keeps counters at least one bit wide for degenerate 1-pixel dimensions.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned COL_W_DEF = clog2_min1(IMG_W_DEF);
    localparam int unsigned ROW_W_DEF = clog2_min1(IMG_H_DEF);
    localparam int unsigned OCC_W_DEF = $clog2(BUF_DEPTH_DEF) + 1;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic                  sol;
        logic                  eol;
        logic                  sof;
        logic                  eof;
    } stream_beat_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Small synchronous register FIFO holding beats captured from the async FIFO read port.
module stream_skid_fifo
    import conv_stream_pkg::*;
#(
    parameter int unsigned DEPTH = BUF_DEPTH_DEF,
    parameter int unsigned W     = DATA_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [W-1:0]           wr_data,
    input  logic                   rd_en,
    output logic [$clog2(DEPTH):0] occ,
    output logic [W-1:0]           head
);

    localparam int unsigned PTR_W = clog2_min1(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic             do_rd;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        do_rd    = rd_en && (occ_q != '0);
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, do_rd})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_stream.sv
// Pops the async pixel FIFO on reserved credit and re-emits a valid/ready stream with line/frame markers.
// Optional stall counter port enabled by FIFO_RD_STREAM_STALL_CNT_EN.
module fifo_rd_stream
    import conv_stream_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned IMG_W     = IMG_W_DEF,
    parameter int unsigned IMG_H     = IMG_H_DEF,
    parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_rd_empty,
    input  logic              fifo_almost_empty,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sol,
    output logic              m_eol,
    output logic              m_sof,
    output logic              m_eof
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int unsigned COL_W = clog2_min1(IMG_W);
    localparam int unsigned ROW_W = clog2_min1(IMG_H);
    localparam int unsigned OCC_W = $clog2(BUF_DEPTH) + 1;

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_H - 1);
    localparam logic [OCC_W:0]   CREDIT_MAX = (OCC_W + 1)'(BUF_DEPTH);

    logic              inflight_q, inflight_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [OCC_W-1:0]  occ;
    logic [DATA_W-1:0] head;
    logic              hs;
    logic              unused_ok;

    assign unused_ok = fifo_almost_empty;

    // Every word popped last cycle lands here this cycle; its slot was reserved when it was popped.
    stream_skid_fifo #(
        .DEPTH (BUF_DEPTH),
        .W     (DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (inflight_q),
        .wr_data (fifo_rd_data),
        .rd_en   (m_ready),
        .occ     (occ),
        .head    (head)
    );

    always_comb begin
        fifo_rd_en = rst_n && !fifo_rd_empty
                     && (({1'b0, occ} + {{OCC_W{1'b0}}, inflight_q}) < CREDIT_MAX);
        inflight_d = fifo_rd_en;
        m_valid    = (occ != '0);
        m_data     = head;
        hs         = m_valid && m_ready;

        col_d = col_q;
        row_d = row_q;
        if (hs) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        m_sol = m_valid && (col_q == '0);
        m_eol = m_valid && (col_q == COL_LAST);
        m_sof = m_sol && (row_q == '0);
        m_eof = m_eol && (row_q == ROW_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            col_q      <= col_d;
            row_q      <= row_d;
        end
    end

`ifdef FIFO_RD_STREAM_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hs && m_sof) begin
            stall_cnt_d = '0;
        end else if (m_valid && !m_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized bench for fifo_rd_stream: emulated async FIFO source plus a queue-based reference of the stream.
module tb_fifo_rd_stream;

    localparam int unsigned DW = 8;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;
    localparam int unsigned D  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_empty;
    logic          fifo_almost_empty;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_sol, m_eol, m_sof, m_eof;
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    fifo_rd_stream #(
        .DATA_W    (DW),
        .IMG_W     (W),
        .IMG_H     (H),
        .BUF_DEPTH (D)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fifo_rd_en        (fifo_rd_en),
        .fifo_rd_data      (fifo_rd_data),
        .fifo_rd_empty     (fifo_rd_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .m_data            (m_data),
        .m_sol             (m_sol),
        .m_eol             (m_eol),
        .m_sof             (m_sof),
        .m_eof             (m_eof)
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
        ,
        .stall_cnt         (stall_cnt)
`endif
    );

    int unsigned   n_cmp = 0;
    int unsigned   n_bad = 0;

    logic [DW-1:0] src_q[$];
    logic [DW-1:0] buf_q[$];
    logic [DW-1:0] out_log[$];
    logic [DW-1:0] ref_log[$];
    logic          infl = 1'b0;
    logic [DW-1:0] infl_word = '0;
    int unsigned   beats = 0;
    int unsigned   dut_pops = 0;
    logic [31:0]   sc_m = '0;
    int unsigned   rdy_mode = 0;
    logic          gap_mode = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    int            cyc = 0;
    int            first_en = -1;
    int            first_v = -1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic load(input int unsigned n, input logic count_down);
        logic [DW-1:0] w;
        for (int unsigned i = 0; i < n; i++) begin
            w = count_down ? DW'(255 - i) : DW'($urandom);
            src_q.push_back(w);
            ref_log.push_back(w);
        end
    endtask

    // One clock: drive inputs after the falling edge, check, then advance the model past the rising edge.
    task automatic step();
        logic        exp_valid, exp_en, hs;
        logic [3:0]  exp_mk;
        int unsigned pos;
        fifo_rd_data  = infl ? infl_word : DW'($urandom);
        fifo_rd_empty = (src_q.size() == 0) || (gap_mode && ($urandom_range(0, 3) == 0));
        fifo_almost_empty = (src_q.size() < 4);
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'b0;
            default: m_ready = ($urandom_range(0, 4) == 0) ? m_ready : ~m_ready;
        endcase
        #1;
        exp_valid = (buf_q.size() != 0);
        exp_en    = !fifo_rd_empty && ((buf_q.size() + int'(infl)) < D);
        pos       = beats % (W * H);
        exp_mk    = exp_valid ? {pos == 0, (pos % W) == 0, (pos % W) == W - 1, pos == W * H - 1} : 4'b0000;

        check_eq("rd_en", 32'(fifo_rd_en), 32'(exp_en));
        check_eq("rd_while_empty", 32'(fifo_rd_en & fifo_rd_empty), 32'(0));
        check_eq("m_valid", 32'(m_valid), 32'(exp_valid));
        check_eq("markers", 32'({m_sof, m_sol, m_eol, m_eof}), 32'(exp_mk));
        if (exp_valid) check_eq("m_data", 32'(m_data), 32'(buf_q[0]));
        if (prev_stall) check_eq("hold", 32'(m_data), 32'(prev_data));
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
        check_eq("stall_cnt", stall_cnt, sc_m);
`endif
        if (first_en < 0 && fifo_rd_en) first_en = cyc;
        if (first_v < 0 && m_valid) first_v = cyc;
        if (fifo_rd_en) dut_pops++;

        hs         = exp_valid && m_ready;
        prev_stall = exp_valid && !m_ready;
        prev_data  = exp_valid ? buf_q[0] : '0;
        if (hs && pos == 0) sc_m = '0;
        else if (exp_valid && !m_ready && sc_m != 32'hFFFF_FFFF) sc_m = sc_m + 1;
        if (hs) begin
            void'(buf_q.pop_front());
            out_log.push_back(m_data);
            beats++;
        end
        if (infl) buf_q.push_back(infl_word);
        infl = exp_en;
        if (exp_en) infl_word = src_q.pop_front();
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n = 0;
        while ((src_q.size() != 0 || buf_q.size() != 0 || infl) && n < budget) begin
            step();
            n++;
        end
        check_eq("drain", 32'(src_q.size() + buf_q.size() + int'(infl)), 32'(0));
    endtask

    task automatic compare_logs(input string tag);
        check_eq({tag, "_count"}, 32'(out_log.size()), 32'(ref_log.size()));
        for (int k = 0; k < ref_log.size() && k < out_log.size(); k++) begin
            check_eq(tag, 32'(out_log[k]), 32'(ref_log[k]));
        end
        out_log.delete();
        ref_log.delete();
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_rd_en", 32'(fifo_rd_en), 32'(0));
        check_eq("rst_m_valid", 32'(m_valid), 32'(0));
        check_eq("rst_m_data", 32'(m_data), 32'(0));
        check_eq("rst_markers", 32'({m_sof, m_sol, m_eol, m_eof}), 32'(0));
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
        check_eq("rst_stall_cnt", stall_cnt, 32'(0));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        rst_n             = 1'b0;
        fifo_rd_empty     = 1'b0;
        fifo_almost_empty = 1'b1;
        fifo_rd_data      = '0;
        m_ready           = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Descending 256-word preload streamed at full rate.
        load(256, 1'b1);
        rdy_mode = 0;
        gap_mode = 1'b0;
        first_en = -1;
        first_v  = -1;
        drain(400);
        check_eq("latency", 32'(first_v - first_en), 32'(2));
        compare_logs("seq_down");

        // Backpressure: hold ready low with a loaded FIFO.
        load(20, 1'b0);
        rdy_mode = 1;
        dut_pops = 0;
        repeat (12) step();
        check_eq("bp_pops", 32'(dut_pops), 32'(D));
        check_eq("bp_rd_en", 32'(fifo_rd_en), 32'(0));
        check_eq("bp_hold_first", 32'(m_data), 32'(ref_log[0]));
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
        check_eq("stall_cnt_10", stall_cnt, 32'(10));
`endif
        rdy_mode = 0;
        step();
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
        check_eq("stall_cnt_sof_clr", stall_cnt, 32'(0));
`endif
        drain(100);
        compare_logs("bp");

        // Toggling ready with random empty gaps.
        load(200, 1'b0);
        rdy_mode = 2;
        gap_mode = 1'b1;
        drain(3000);
        compare_logs("rand");

        // Reset in the middle of a line at col 2.
        load(30, 1'b0);
        rdy_mode = 0;
        gap_mode = 1'b0;
        n = 0;
        while (!((beats % W) == 2 && buf_q.size() != 0) && n < 100) begin
            step();
            n++;
        end
        check_eq("reach_col2", 32'(beats % W), 32'(2));
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        src_q.delete();
        buf_q.delete();
        out_log.delete();
        ref_log.delete();
        infl       = 1'b0;
        beats      = 0;
        sc_m       = '0;
        prev_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        load(10, 1'b0);
        n = 0;
        while (!m_valid && n < 20) begin
            step();
            n++;
        end
        check_eq("post_rst_sof_sol", 32'({m_sof, m_sol}), 32'(2'b11));
        drain(100);
        compare_logs("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
